// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transceiver:
//   tx_state_t  - transmit FSM states
//   rx_state_t  - receive FSM states
//   calc_cycle  - clocks per bit from clock frequency (MHz) and baud rate
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_HOLD
    } rx_state_t;

    // Clocks per bit, integer truncation (868 at 100 MHz / 115200 baud).
    function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                               input int unsigned baud_rate);
        return (clk_fre * 32'd1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_path.sv
// -----------------------------------------------------------------------------
// uart_rx_path
// 8N1 deserialiser with a valid/ready byte output.
//   clk, rst_n     - system clock, async active-low reset
//   rx_pin         - serial line, asynchronous to clk
//   rx_data        - received byte, stable while rx_data_valid
//   rx_data_valid  - a new byte is held
//   rx_data_ready  - consumer accepts on valid&&ready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 100,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready
);

    localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int          CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          fall;

    // Two-flop synchroniser plus one delay stage for edge detection. Reset
    // to the idle-high line level so reset release never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RX_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (fall) state <= RX_START;
                end
                RX_START: begin
                    // Half-bit check rejects glitches and aligns later
                    // samples to bit centres.
                    if (cnt == CW'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CYCLE - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CYCLE - 1)) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            rx_data       <= shreg;
                            rx_data_valid <= 1'b1;
                            state         <= RX_HOLD;
                        end else begin
                            // Framing error: discard the byte silently.
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_HOLD: begin
                    // Line activity is ignored here; frames arriving now drop.
                    if (rx_data_ready) begin
                        rx_data_valid <= 1'b0;
                        state         <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_path.sv
// -----------------------------------------------------------------------------
// uart_tx_path
// 8N1 serialiser with a valid/ready byte input.
//   clk, rst_n     - system clock, async active-low reset
//   tx_data        - byte to send, captured on valid&&ready
//   tx_data_valid  - tx_data is valid
//   tx_data_ready  - registered; high while idle
//   tx_pin         - serial line, idle high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_tx_path
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 100,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);

    localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int          CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

    tx_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_done;

    assign bit_done = (cnt == CW'(CYCLE - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= TX_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            tx_pin        <= 1'b1;
            tx_data_ready <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx_pin <= 1'b1;
                    cnt    <= '0;
                    if (tx_data_valid && tx_data_ready) begin
                        // Byte is latched here, so later tx_data changes do
                        // not disturb the frame in flight.
                        shreg         <= tx_data;
                        tx_data_ready <= 1'b0;
                        tx_pin        <= 1'b0;
                        state         <= TX_START;
                    end else begin
                        tx_data_ready <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_pin  <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        // Shift so the next bit to send is always in shreg[1].
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx_pin <= 1'b1;
                            state  <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_pin  <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        cnt           <= '0;
                        tx_data_ready <= 1'b1;
                        state         <= TX_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// -----------------------------------------------------------------------------
// uart_transceiver
// Full-duplex 8N1 UART; independent TX and RX paths, shared clock and reset.
//   clk, rst_n                            - system clock, async active-low reset
//   tx_data, tx_data_valid, tx_data_ready - transmit byte stream
//   tx_pin                                - serial output, idle high
//   rx_data, rx_data_valid, rx_data_ready - receive byte stream
//   rx_pin                                - serial input, asynchronous
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 100,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic       rx_pin
);

    uart_tx_path #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin)
    );

    uart_rx_path #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// -----------------------------------------------------------------------------
// tb_uart_transceiver
// Loopback bench: tx_pin drives rx_pin unless a direct line-injection mode is
// selected for glitch and framing-error frames. Expected line bits come from
// the 8N1 frame rule; expected received bytes come from a queue of sent bytes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transceiver;

    localparam int BIT_NS  = 8680;  // 868 clocks at 10 ns
    localparam int HALF_NS = 4345;  // bit centre, aligned to a falling clk edge

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_pin;
    logic       use_inj;
    logic       inj_pin;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   rx_count = 0;
    time  t_rise = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign rx_pin = use_inj ? inj_pin : tx_pin;

    uart_transceiver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_pin        (rx_pin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level of each bit slot: start 0, data LSB first, stop 1.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9] = 1'b1;
        return f;
    endfunction

    // Offer a byte, wait for acceptance, then check every bit centre of the
    // frame. Returns at the stop-bit centre with the acceptance edge time.
    task automatic send_byte(input logic [7:0] b, input bit expect_rx, output time t_acc);
        logic [9:0] fb;
        int         waited;
        time        target;
        fb = frame_bits(b);
        @(negedge clk);
        tx_data       = b;
        tx_data_valid = 1'b1;
        waited        = 0;
        while (!tx_data_ready && waited < 3 * 11 * 868) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", tx_data_ready, 1'b1);
        @(posedge clk);
        t_acc = $time;
        #1;
        tx_data_valid = 1'b0;
        tx_data       = 8'($urandom);
        if (expect_rx) exp_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            target = t_acc + time'(k * BIT_NS + HALF_NS);
            #(target - $time);
            check($sformatf("tx_bit%0d", k), tx_pin, fb[k]);
            check($sformatf("tx_busy%0d", k), tx_data_ready, 1'b0);
        end
    endtask

    // Drive a frame straight onto rx_pin with a chosen stop-bit level.
    task automatic inj_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fb;
        fb    = frame_bits(b);
        fb[9] = stop_bit;
        for (int k = 0; k < 10; k++) begin
            inj_pin = fb[k];
            #(BIT_NS);
        end
        inj_pin = 1'b1;
        #(BIT_NS);
    endtask

    // Receive monitor: every cycle with valid high must show the oldest
    // outstanding byte; a byte retires when ready is also high.
    initial begin : rx_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rx_data_valid === 1'b1) begin
                if (!prev) begin
                    rx_count++;
                    t_rise = $time;
                end
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", rx_data_valid, 1'b0);
                end else begin
                    check("rx_data", rx_data, exp_q[0]);
                    if (rx_data_ready) void'(exp_q.pop_front());
                end
            end
            prev = rx_data_valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        time t0, t1, tprev;
        int  saved;
        int  waited;
        logic [7:0] b;

        rst_n         = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        rx_data_ready = 1'b1;
        use_inj       = 1'b0;
        inj_pin       = 1'b1;

        // Reset values.
        #50;
        check("rst_tx_pin", tx_pin, 1'b1);
        check("rst_tx_ready", tx_data_ready, 1'b0);
        check("rst_rx_valid", rx_data_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        #50 rst_n = 1'b1;
        #2;
        check("ready_before_edge", tx_data_ready, 1'b0);
        #8;
        check("ready_after_edge", tx_data_ready, 1'b1);
        #90;

        // 0xA5 loopback: line bits, ready timing, receive latency.
        send_byte(8'hA5, 1'b1, t0);
        #((t0 + time'(10 * BIT_NS - 5)) - $time);
        check("ready_stop_end_low", tx_data_ready, 1'b0);
        #10;
        check("ready_stop_end_high", tx_data_ready, 1'b1);
        check("rx_count_a5", rx_count, 1);
        check("rx_latency_a5", ((t_rise - t0) >= 82440) && ((t_rise - t0) <= 82550), 1'b1);

        // Random bytes back to back; no idle bit between frames.
        tprev = 0;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, t1);
            if (i > 0) check("b2b_gap", (t1 - tprev) <= time'(10 * BIT_NS + 20), 1'b1);
            tprev = t1;
        end
        #(BIT_NS);
        check("rx_drained", exp_q.size(), 0);

        // Hold: consumer not ready, byte must stay presented.
        @(posedge clk);
        #1 rx_data_ready = 1'b0;
        saved = rx_count;
        send_byte(8'h3C, 1'b1, t1);
        waited = 0;
        while (rx_data_valid !== 1'b1 && waited < 2 * 868) begin
            @(negedge clk);
            waited++;
        end
        check("hold_valid_rise", rx_data_valid, 1'b1);
        repeat (20) @(negedge clk);
        check("hold_valid_kept", rx_data_valid, 1'b1);
        check("hold_data", rx_data, 8'h3C);
        @(posedge clk);
        #1 rx_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_release", rx_data_valid, 1'b0);
        check("hold_one_byte", rx_count, saved + 1);
        check("hold_popped", exp_q.size(), 0);

        // Glitch on the line: rejected at the half-bit check.
        use_inj = 1'b1;
        saved   = rx_count;
        @(negedge clk);
        inj_pin = 1'b0;
        #100 inj_pin = 1'b1;
        #(2 * BIT_NS);
        check("glitch_no_frame", rx_count, saved);
        check("glitch_valid_low", rx_data_valid, 1'b0);

        // Framing error, then a good frame must still be received.
        inj_frame(8'($urandom), 1'b0);
        check("framing_dropped", rx_count, saved);
        use_inj = 1'b0;
        send_byte(8'h3C, 1'b1, t1);
        #(BIT_NS);
        check("after_ferr_count", rx_count, saved + 1);
        check("after_ferr_drained", exp_q.size(), 0);

        // Reset in the middle of a frame: both paths abort, nothing emerges.
        saved = rx_count;
        @(negedge clk);
        tx_data       = 8'($urandom);
        tx_data_valid = 1'b1;
        @(posedge clk);
        #1 tx_data_valid = 1'b0;
        #(3 * BIT_NS);
        rst_n = 1'b0;
        #5;
        check("midrst_tx_pin", tx_pin, 1'b1);
        check("midrst_tx_ready", tx_data_ready, 1'b0);
        check("midrst_rx_valid", rx_data_valid, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        #95 rst_n = 1'b1;
        #(8 * BIT_NS);
        check("midrst_no_partial", rx_count, saved);
        check("midrst_tx_idle", tx_pin, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
